collision_controller: RTL and testbench
=======================================

Name: collision_controller

Overview:
- Parametrised successor to the fixed four-border/one-flipper game controller.
- Detects per-pixel overlap between the ball and N_TARGETS drawable objects, and accumulates hits over a frame.
- Issues one-cycle per-target collision pulses at frame boundary.
- Owns game state: play, pause, ball-lost respawn delay, game over, lives and saturating score.
- Sits between the object draw blocks and the ball/flipper movers; its pause output gates all motion.

Parameters:
- N_TARGETS, 6, number of target draw flags (borders, flippers, bumpers).
- BOTTOM_IDX, 1, index of the target that costs a life when hit.
- SCORE_MASK, 6'b110000, per-target bit: 1 = hit adds score.
- SCORE_PER_HIT, 10, score added per scoring target hit per frame.
- SCORE_W, 16, score width.
- LIVES_INIT, 3, lives after reset/restart (≥1).
- RESPAWN_FRAMES, 60, frames held in BALL_LOST.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous active-high reset
- startOfFrame  in  1  one-cycle pulse from VGA controller
- draw_ball  in  1  ball pixel active
- draw_targets  in  N_TARGETS  per-target pixel active
- pauseKey  in  1  level, key held
- restartKey  in  1  level, key held
- collision  out  N_TARGETS  per-target hit pulse, one cycle per frame
- collisionAny  out  1  OR of collision
- pause  out  1  1 whenever state ≠ PLAY
- gameOver  out  1  state == GAME_OVER
- lives  out  $clog2(LIVES_INIT+1)  remaining lives
- score  out  SCORE_W  accumulated score

Behaviour:
- Reset, synchronous and active-high, applies on any cycle, mid-frame included:
  - state=PLAY, hitAcc=0, collision=0, lives=LIVES_INIT, score=0, respawn counter=0, key history=0.
  - Outputs: pause=0, gameOver=0, collisionAny=0.
- Key edge detect: keyRise = key & ~key_q, with key_q registered each cycle. A held key produces exactly one edge.
- Accumulation:
  - Each cycle with state==PLAY, hitAcc[i] |= draw_ball & draw_targets[i].
  - Overlaps are ignored in other states.
- Frame boundary (startOfFrame==1):
  - Next cycle: collision <= hitAcc, pulsed for exactly one cycle. Latency is 1 clk after startOfFrame.
  - hitAcc <= overlap of the current cycle only. A startOfFrame-cycle overlap belongs to the new frame.
  - Outside frame boundaries, collision is 0.
- Score update, same edge as the collision pulse:
  - score += SCORE_PER_HIT × popcount(hitAcc & SCORE_MASK).
  - Computed in SCORE_W+4 bits, then saturated at 2^SCORE_W−1; never wraps.
- FSM, evaluated at the frame-boundary edge unless noted:
  - PLAY: if hitAcc[BOTTOM_IDX], lives decrements by 1.
    - If new lives==0, go to GAME_OVER.
    - Otherwise go to BALL_LOST with respawn counter=0.
    - Else, on pauseKey rise (any cycle), go to PAUSED.
    - Ball loss has priority over a same-cycle pause edge.
  - PAUSED: pauseKey rise → PLAY. hitAcc is held, not cleared.
  - BALL_LOST: counter increments on each startOfFrame. When it reaches RESPAWN_FRAMES−1 at a startOfFrame, go to PLAY. pauseKey is ignored.
  - GAME_OVER: restartKey rise → PLAY, lives=LIVES_INIT, score=0, hitAcc=0. Other keys are ignored.
- Scoring still applies on the frame a life is lost. Score never changes outside PLAY boundaries.
- lives never underflows; GAME_OVER is reached at 0.

Decomposition:
- Package pinball_pkg:
  - game_state_t enum {PLAY, PAUSED, BALL_LOST, GAME_OVER}.
  - Default constants: N_TARGETS, BOTTOM_IDX, LIVES_INIT, RESPAWN_FRAMES.
  - Target index constants: TGT_TOP, TGT_BOTTOM, TGT_LEFT, TGT_RIGHT, TGT_FLIPPER, TGT_BUMPER.
- Sub-module key_edge_detect (clk, reset, key → rise), instantiated twice.

Test Plan:
- Reset mid-frame with hitAcc nonzero → next cycle all outputs zero, lives=3, score=0; the next frame produces no collision pulse.
- Overlap on target 4 for 5 cycles in one frame, then startOfFrame → collision=6'b010000 for exactly 1 cycle, 1 clk after startOfFrame; score=10, not 50.
- Targets 4 and 5 both hit in one frame with score=65530 → score saturates to 65535; collisionAny pulses once.
- Bottom (idx 1) hit in frame → lives 3→2, pause=1 for 60 frames, then PLAY. A pauseKey edge during BALL_LOST has no effect.
- Three bottom hits → lives=0, gameOver=1. restartKey held 100 cycles → single restart, lives=3, score=0, pause=0.
- pauseKey rise and bottom hit on the same startOfFrame cycle → BALL_LOST, not PAUSED. Overlaps during PAUSED produce no collision and no score change.

Source files
------------

// File: rtl/pinball_pkg.sv
// Shared game-state type and default geometry constants for the pinball controller slice.
package pinball_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        PAUSED    = 2'd1,
        BALL_LOST = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam int N_TARGETS      = 6;
    localparam int BOTTOM_IDX     = 1;
    localparam int LIVES_INIT     = 3;
    localparam int RESPAWN_FRAMES = 60;

    // Bit positions of the draw flags in draw_targets
    localparam int TGT_TOP     = 0;
    localparam int TGT_BOTTOM  = 1;
    localparam int TGT_LEFT    = 2;
    localparam int TGT_RIGHT   = 3;
    localparam int TGT_FLIPPER = 4;
    localparam int TGT_BUMPER  = 5;

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for a level key input; a held key yields a single one-cycle pulse.
module key_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic rise
);

    logic key_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key;
        end
    end

    assign rise = key & ~key_q;

endmodule

// File: rtl/collision_controller.sv
// Ball/target overlap accumulator with per-frame collision pulses, plus the play/pause/respawn/game-over
// state machine that owns lives and the saturating score.
module collision_controller
    import pinball_pkg::*;
#(
    parameter int                    N_TARGETS      = pinball_pkg::N_TARGETS,
    parameter int                    BOTTOM_IDX     = pinball_pkg::BOTTOM_IDX,
    parameter logic [N_TARGETS-1:0]  SCORE_MASK     = 6'b110000,
    parameter int                    SCORE_PER_HIT  = 10,
    parameter int                    SCORE_W        = 16,
    parameter int                    LIVES_INIT     = pinball_pkg::LIVES_INIT,
    parameter int                    RESPAWN_FRAMES = pinball_pkg::RESPAWN_FRAMES,
    localparam int                   LIVES_W        = $clog2(LIVES_INIT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 draw_ball,
    input  logic [N_TARGETS-1:0] draw_targets,
    input  logic                 pauseKey,
    input  logic                 restartKey,
    output logic [N_TARGETS-1:0] collision,
    output logic                 collisionAny,
    output logic                 pause,
    output logic                 gameOver,
    output logic [LIVES_W-1:0]   lives,
    output logic [SCORE_W-1:0]   score
);

    localparam int ACC_W = SCORE_W + 4;
    localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

    logic pause_rise;
    logic restart_rise;

    key_edge_detect u_pause_edge (
        .clk   (clk),
        .reset (reset),
        .key   (pauseKey),
        .rise  (pause_rise)
    );

    key_edge_detect u_restart_edge (
        .clk   (clk),
        .reset (reset),
        .key   (restartKey),
        .rise  (restart_rise)
    );

    logic [N_TARGETS-1:0] overlap;

    for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_overlap
        assign overlap[gi] = draw_ball & draw_targets[gi];
    end

    game_state_t          state_reg;
    logic [N_TARGETS-1:0] hit_acc_reg;
    logic [N_TARGETS-1:0] collision_reg;
    logic                 collision_any_reg;
    logic [LIVES_W-1:0]   lives_reg;
    logic [SCORE_W-1:0]   score_reg;
    logic [CNT_W-1:0]     respawn_cnt_reg;

    logic [ACC_W-1:0]     score_gain;
    logic [ACC_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_next;

    // Each scoring target counts once per frame, however many pixels overlapped
    always_comb begin
        score_gain = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (hit_acc_reg[i] && SCORE_MASK[i]) begin
                score_gain = score_gain + ACC_W'(SCORE_PER_HIT);
            end
        end
        score_sum  = ACC_W'(score_reg) + score_gain;
        score_next = (|score_sum[ACC_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= PLAY;
            hit_acc_reg       <= '0;
            collision_reg     <= '0;
            collision_any_reg <= 1'b0;
            lives_reg         <= LIVES_W'(LIVES_INIT);
            score_reg         <= '0;
            respawn_cnt_reg   <= '0;
        end else begin
            collision_reg     <= '0;
            collision_any_reg <= 1'b0;
            case (state_reg)
                PLAY: begin
                    if (startOfFrame) begin
                        collision_reg     <= hit_acc_reg;
                        collision_any_reg <= |hit_acc_reg;
                        score_reg         <= score_next;
                        // Ball loss wins over a pause edge landing on the same boundary
                        if (hit_acc_reg[BOTTOM_IDX]) begin
                            lives_reg       <= lives_reg - LIVES_W'(1);
                            hit_acc_reg     <= '0;
                            respawn_cnt_reg <= '0;
                            state_reg       <= (lives_reg == LIVES_W'(1)) ? GAME_OVER : BALL_LOST;
                        end else begin
                            hit_acc_reg <= overlap;
                            if (pause_rise) begin
                                state_reg <= PAUSED;
                            end
                        end
                    end else begin
                        hit_acc_reg <= hit_acc_reg | overlap;
                        if (pause_rise) begin
                            state_reg <= PAUSED;
                        end
                    end
                end
                PAUSED: begin
                    if (pause_rise) begin
                        state_reg <= PLAY;
                    end
                end
                BALL_LOST: begin
                    if (startOfFrame) begin
                        if (respawn_cnt_reg == CNT_W'(RESPAWN_FRAMES - 1)) begin
                            state_reg       <= PLAY;
                            respawn_cnt_reg <= '0;
                        end else begin
                            respawn_cnt_reg <= respawn_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                GAME_OVER: begin
                    if (restart_rise) begin
                        state_reg   <= PLAY;
                        lives_reg   <= LIVES_W'(LIVES_INIT);
                        score_reg   <= '0;
                        hit_acc_reg <= '0;
                    end
                end
                default: state_reg <= PLAY;
            endcase
        end
    end

    assign collision    = collision_reg;
    assign collisionAny = collision_any_reg;
    assign pause        = (state_reg != PLAY);
    assign gameOver     = (state_reg == GAME_OVER);
    assign lives        = lives_reg;
    assign score        = score_reg;

endmodule

// File: tb/tb_collision_controller.sv
// Randomized and directed bench for collision_controller against a frame-level game model.
module tb_collision_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       draw_ball = 1'b0;
    logic [5:0] draw_targets = 6'b0;
    logic       pauseKey = 1'b0;
    logic       restartKey = 1'b0;
    logic [5:0] collision;
    logic       collisionAny;
    logic       pause;
    logic       gameOver;
    logic [1:0] lives;
    logic [15:0] score;

    always #5 clk = ~clk;

    collision_controller dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .draw_ball    (draw_ball),
        .draw_targets (draw_targets),
        .pauseKey     (pauseKey),
        .restartKey   (restartKey),
        .collision    (collision),
        .collisionAny (collisionAny),
        .pause        (pause),
        .gameOver     (gameOver),
        .lives        (lives),
        .score        (score)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit pk_lvl  = 1'b0;
    bit rk_lvl  = 1'b0;
    bit rst_lvl = 1'b1;

    // Reference game model: modes, a per-frame hit set, and a count of frames spent waiting to respawn
    typedef enum int {M_RUN, M_HOLD, M_LOST, M_OVER} mode_t;
    mode_t  m_mode;
    bit [5:0] m_acc;
    bit [5:0] m_coll;
    int     m_lives;
    int     m_score;
    int     m_lost_frames;
    bit     m_pk_prev;
    bit     m_rk_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode        = M_RUN;
        m_acc         = '0;
        m_coll        = '0;
        m_lives       = 3;
        m_score       = 0;
        m_lost_frames = 0;
        m_pk_prev     = 1'b0;
        m_rk_prev     = 1'b0;
    endtask

    task automatic model_step(input bit sof, input bit ball, input bit [5:0] tg, input bit pk, input bit rk);
        bit       p_edge;
        bit       r_edge;
        bit [5:0] hit_now;
        p_edge    = pk && !m_pk_prev;
        r_edge    = rk && !m_rk_prev;
        m_pk_prev = pk;
        m_rk_prev = rk;
        hit_now   = ball ? tg : 6'b0;
        m_coll    = '0;
        case (m_mode)
            M_RUN: begin
                if (sof) begin
                    m_coll  = m_acc;
                    m_score = m_score + 10 * $countones(m_acc & 6'b110000);
                    if (m_score > 65535) m_score = 65535;
                    if (m_acc[1]) begin
                        m_lives       = m_lives - 1;
                        m_acc         = '0;
                        m_lost_frames = 0;
                        m_mode        = (m_lives == 0) ? M_OVER : M_LOST;
                    end else begin
                        m_acc = hit_now;
                        if (p_edge) m_mode = M_HOLD;
                    end
                end else begin
                    m_acc = m_acc | hit_now;
                    if (p_edge) m_mode = M_HOLD;
                end
            end
            M_HOLD: if (p_edge) m_mode = M_RUN;
            M_LOST: begin
                if (sof) begin
                    m_lost_frames++;
                    if (m_lost_frames == 60) m_mode = M_RUN;
                end
            end
            M_OVER: begin
                if (r_edge) begin
                    m_mode  = M_RUN;
                    m_lives = 3;
                    m_score = 0;
                    m_acc   = '0;
                end
            end
            default: m_mode = M_RUN;
        endcase
    endtask

    task automatic compare_all();
        chk("collision",    collision,    m_coll);
        chk("collisionAny", collisionAny, |m_coll);
        chk("pause",        pause,        m_mode != M_RUN);
        chk("gameOver",     gameOver,     m_mode == M_OVER);
        chk("lives",        lives,        m_lives);
        chk("score",        score,        m_score);
    endtask

    task automatic cyc(input bit sof, input bit ball, input logic [5:0] tg);
        @(negedge clk);
        startOfFrame = sof;
        draw_ball    = ball;
        draw_targets = tg;
        pauseKey     = pk_lvl;
        restartKey   = rk_lvl;
        reset        = rst_lvl;
        if (rst_lvl) model_reset();
        else         model_step(sof, ball, tg, pk_lvl, rk_lvl);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // One frame: boundary cycle, then nhit overlap cycles on tg, then idle cycles
    task automatic frame(input int len, input logic [5:0] tg, input int nhit, input bit verbose);
        cyc(1'b1, 1'b0, 6'b0);
        for (int i = 1; i < len; i++) begin
            cyc(1'b0, i <= nhit, (i <= nhit) ? tg : 6'b0);
        end
        if (verbose)
            $display("frame len=%0d tg=%b hits=%0d : lives=%0d score=%0d pause=%0b gameOver=%0b",
                     len, tg, nhit, lives, score, pause, gameOver);
    endtask

    task automatic wait_respawn(input string tag);
        int n = 0;
        do begin
            pk_lvl = 1'b1;
            cyc(1'b1, 1'b0, 6'b0);
            pk_lvl = 1'b0;
            cyc(1'b0, 1'b0, 6'b0);
            cyc(1'b0, 1'b0, 6'b0);
            n++;
        end while (pause && n < 100);
        chk(tag, n, 60);
        $display("respawn %s: back in play after %0d frames, lives=%0d", tag, n, lives);
    endtask

    initial begin
        #5_000_000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int saved_score;
        model_reset();

        // Power-up reset
        rst_lvl = 1'b1;
        cyc(1'b0, 1'b0, 6'b0);
        cyc(1'b0, 1'b0, 6'b0);
        rst_lvl = 1'b0;
        chk("rst_lives", lives, 3);
        chk("rst_score", score, 0);
        chk("rst_pause", pause, 0);
        $display("reset: lives=%0d score=%0d pause=%0b", lives, score, pause);

        // Flipper overlapped for 5 cycles counts once
        frame(8, 6'b010000, 5, 1'b1);
        cyc(1'b1, 1'b0, 6'b0);
        chk("flipper_pulse", collision, 6'b010000);
        chk("flipper_score", score, 10);
        cyc(1'b0, 1'b0, 6'b0);
        chk("flipper_pulse_width", collision, 6'b0);
        $display("flipper frame: score=%0d", score);

        // Reset mid-frame with hits pending
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 6'b110010);
        rst_lvl = 1'b1;
        cyc(1'b0, 1'b0, 6'b0);
        rst_lvl = 1'b0;
        chk("midrst_lives", lives, 3);
        chk("midrst_score", score, 0);
        cyc(1'b0, 1'b0, 6'b0);
        cyc(1'b1, 1'b0, 6'b0);
        chk("midrst_no_pulse", collision, 6'b0);
        $display("mid-frame reset: collision=%b lives=%0d", collision, lives);

        // Drive score up to 65530, then a double hit must saturate
        for (int i = 0; i < 3276; i++) frame(2, 6'b110000, 1, 1'b0);
        frame(2, 6'b010000, 1, 1'b0);
        chk("pre_sat_score", score, 65520);
        frame(2, 6'b110000, 1, 1'b1);
        chk("pre_sat_score2", score, 65530);
        cyc(1'b1, 1'b0, 6'b0);
        chk("sat_score", score, 65535);
        chk("sat_any", collisionAny, 1);
        cyc(1'b0, 1'b0, 6'b0);
        chk("sat_any_once", collisionAny, 0);
        $display("saturation: score=%0d", score);

        // Bottom hit: one life lost, 60-frame respawn with pause key ignored
        frame(4, 6'b000010, 2, 1'b1);
        cyc(1'b1, 1'b0, 6'b0);
        chk("loss1_lives", lives, 2);
        chk("loss1_pause", pause, 1);
        wait_respawn("respawn1_frames");

        // Pause edge and bottom hit on the same boundary: ball loss wins
        frame(4, 6'b000010, 2, 1'b1);
        pk_lvl = 1'b1;
        cyc(1'b1, 1'b0, 6'b0);
        pk_lvl = 1'b0;
        chk("loss2_lives", lives, 1);
        wait_respawn("respawn2_frames");

        // Paused: overlaps neither pulse nor score
        pk_lvl = 1'b1;
        cyc(1'b0, 1'b0, 6'b0);
        pk_lvl = 1'b0;
        chk("paused", pause, 1);
        saved_score = score;
        frame(5, 6'b110011, 3, 1'b1);
        frame(5, 6'b110011, 3, 1'b1);
        cyc(1'b1, 1'b0, 6'b0);
        chk("paused_no_pulse", collision, 6'b0);
        chk("paused_score", score, saved_score);
        pk_lvl = 1'b1;
        cyc(1'b0, 1'b0, 6'b0);
        pk_lvl = 1'b0;
        chk("unpaused", pause, 0);

        // Last life, then a long restart press
        frame(4, 6'b000010, 2, 1'b1);
        cyc(1'b1, 1'b0, 6'b0);
        chk("over_lives", lives, 0);
        chk("over_flag", gameOver, 1);
        pk_lvl = 1'b1;
        cyc(1'b0, 1'b0, 6'b0);
        pk_lvl = 1'b0;
        cyc(1'b0, 1'b0, 6'b0);
        chk("over_ignores_pause", gameOver, 1);
        rk_lvl = 1'b1;
        for (int i = 0; i < 100; i++) cyc((i % 10) == 9, 1'b1, 6'b010000);
        rk_lvl = 1'b0;
        chk("restart_lives", lives, 3);
        chk("restart_pause", pause, 0);
        chk("restart_over", gameOver, 0);
        $display("restart: lives=%0d score=%0d", lives, score);

        // Random play against the model
        for (int f = 0; f < 300; f++) begin
            int len;
            len = $urandom_range(2, 8);
            for (int c = 0; c < len; c++) begin
                logic [5:0] tg;
                tg = 6'($urandom);
                if ($urandom_range(0, 7) != 0) tg[1] = 1'b0;
                if ($urandom_range(0, 15) == 0) pk_lvl = ~pk_lvl;
                if ($urandom_range(0, 15) == 0) rk_lvl = ~rk_lvl;
                rst_lvl = ($urandom_range(0, 499) == 0);
                cyc(c == 0, $urandom_range(0, 3) == 0, tg);
            end
            rst_lvl = 1'b0;
            $display("rand frame %0d len=%0d : collision=%b lives=%0d score=%0d pause=%0b gameOver=%0b",
                     f, len, collision, lives, score, pause, gameOver);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
